// File: rtl/scan_chain_ctrl.sv
// Scan-chain sequencer: serializes host words into the DPE scan chain LSB first
// and deserializes the displaced chain bits into readback words.
module scan_chain_ctrl #(
   parameter int unsigned CHAIN_LEN = 64,
   parameter int unsigned WORD_W    = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              capture,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              sr_d,
   output logic              sr_en,
   output logic              sr_ld,
   input  logic              sr_q
);

   localparam int unsigned NWORDS = CHAIN_LEN / WORD_W;
   localparam int unsigned BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int unsigned WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
   localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(NWORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CAPT, S_FETCH, S_SHIFT, S_DRAIN, S_DONE
   } state_t;

   state_t              state, state_d;
   logic [BIT_W-1:0]    bit_cnt, bit_cnt_d;
   logic [WCNT_W-1:0]   word_cnt, word_cnt_d;
   logic [WORD_W-1:0]   shift_word, shift_word_d;
   logic [WORD_W-1:0]   rd_word, rd_word_d;

   logic                busy_d, done_d, in_ready_d, out_valid_d;
   logic                sr_d_d, sr_en_d, sr_ld_d;
   logic [WORD_W-1:0]   out_data_d;

   // Next-state, datapath and next-output decode; outputs follow the next state
   // so every strobe is aligned with the state it belongs to.
   always_comb begin
      state_d      = state;
      bit_cnt_d    = bit_cnt;
      word_cnt_d   = word_cnt;
      shift_word_d = shift_word;
      rd_word_d    = rd_word;

      case (state)
         S_IDLE: begin
            if (start) state_d = capture ? S_CAPT : S_FETCH;
         end
         S_CAPT: state_d = S_FETCH;
         S_FETCH: begin
            if (in_valid && in_ready) begin
               shift_word_d = in_data;
               bit_cnt_d    = '0;
               state_d      = S_SHIFT;
            end
         end
         S_SHIFT: begin
            rd_word_d[bit_cnt] = sr_q;
            if (bit_cnt == BIT_LAST) begin
               bit_cnt_d = '0;
               state_d   = S_DRAIN;
            end else begin
               bit_cnt_d = bit_cnt + BIT_W'(1);
            end
         end
         S_DRAIN: begin
            if (out_valid && out_ready) begin
               if (word_cnt == WORD_LAST) begin
                  state_d = S_DONE;
               end else begin
                  word_cnt_d = word_cnt + WCNT_W'(1);
                  state_d    = S_FETCH;
               end
            end
         end
         S_DONE: begin
            word_cnt_d = '0;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over every transition; the chain is left where it stopped.
      if (abort) begin
         state_d      = S_IDLE;
         bit_cnt_d    = '0;
         word_cnt_d   = '0;
         shift_word_d = '0;
         rd_word_d    = '0;
      end

      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
      in_ready_d  = (state_d == S_FETCH);
      out_valid_d = (state_d == S_DRAIN);
      out_data_d  = (state_d == S_DRAIN) ? rd_word_d : '0;
      sr_en_d     = (state_d == S_SHIFT);
      sr_ld_d     = (state_d == S_CAPT);
      sr_d_d      = (state_d == S_SHIFT) ? shift_word_d[bit_cnt_d] : 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         bit_cnt    <= '0;
         word_cnt   <= '0;
         shift_word <= '0;
         rd_word    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         sr_d       <= 1'b0;
         sr_en      <= 1'b0;
         sr_ld      <= 1'b0;
      end else begin
         state      <= state_d;
         bit_cnt    <= bit_cnt_d;
         word_cnt   <= word_cnt_d;
         shift_word <= shift_word_d;
         rd_word    <= rd_word_d;
         busy       <= busy_d;
         done       <= done_d;
         in_ready   <= in_ready_d;
         out_valid  <= out_valid_d;
         out_data   <= out_data_d;
         sr_d       <= sr_d_d;
         sr_en      <= sr_en_d;
         sr_ld      <= sr_ld_d;
      end
   end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with a 16-bit behavioural scan chain.
module tb_scan_chain_ctrl;

   localparam int unsigned CHAIN_LEN = 16;
   localparam int unsigned WORD_W    = 8;
   localparam int TMO = 200;

   logic clk = 1'b0;
   logic rstn, start, capture, abort;
   logic busy, done, in_valid, in_ready, out_valid, out_ready;
   logic [WORD_W-1:0] in_data, out_data;
   logic sr_d, sr_en, sr_ld, sr_q;

   logic [CHAIN_LEN-1:0] chain;
   logic [CHAIN_LEN-1:0] pd = '0;
   int en_cnt = 0, ld_cnt = 0, done_cnt = 0, overlap = 0, ld_en_snap = 0;
   int n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   scan_chain_ctrl #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
      .clk(clk), .rstn(rstn), .start(start), .capture(capture), .abort(abort),
      .busy(busy), .done(done), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .sr_d(sr_d), .sr_en(sr_en), .sr_ld(sr_ld), .sr_q(sr_q)
   );

   // Chain model: parallel load or shift toward bit 0, cleared by rstn.
   assign sr_q = chain[0];
   always @(posedge clk or negedge rstn) begin
      if (!rstn) chain <= '0;
      else if (sr_ld) chain <= pd;
      else if (sr_en) chain <= {sr_d, chain[CHAIN_LEN-1:1]};
   end

   always @(posedge clk) begin
      if (sr_en) en_cnt <= en_cnt + 1;
      if (sr_ld) begin
         ld_cnt     <= ld_cnt + 1;
         ld_en_snap <= en_cnt;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (sr_en && sr_ld) overlap <= overlap + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic do_start(input logic cap);
      start = 1'b1; capture = cap;
      @(negedge clk);
      start = 1'b0; capture = 1'b0;
   endtask

   task automatic feed(input logic [WORD_W-1:0] w, input int stall);
      int t = 0;
      logic bad = 1'b0;
      while (!in_ready && t < TMO) begin @(negedge clk); t++; end
      if (t == TMO) check("in_ready timeout", 32'(in_ready), 32'd1);
      for (int k = 0; k < stall; k++) begin
         if (sr_en || !in_ready) bad = 1'b1;
         @(negedge clk);
      end
      if (stall > 0) check("fetch stall", 32'(bad), 32'd0);
      in_valid = 1'b1; in_data = w;
      @(negedge clk);
      in_valid = 1'b0; in_data = '0;
   endtask

   task automatic drain(input int stall, output logic [WORD_W-1:0] rw);
      int t = 0;
      logic bad = 1'b0;
      while (!out_valid && t < TMO) begin @(negedge clk); t++; end
      if (t == TMO) check("out_valid timeout", 32'(out_valid), 32'd1);
      rw = out_data;
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         if (out_data !== rw || !out_valid || sr_en) bad = 1'b1;
      end
      if (stall > 0) check("drain stall", 32'(bad), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // Starts a pass, shifts one word partially, then aborts or resets.
   task automatic interrupt(input logic use_reset, input int shifts);
      int en_s = en_cnt, dn_s = done_cnt, t = 0;
      do_start(1'b0);
      feed(8'hFF, 0);
      while ((en_cnt - en_s) < shifts && t < TMO) begin @(negedge clk); t++; end
      if (t == TMO) check("shift timeout", 32'(en_cnt - en_s), 32'(shifts));
      if (use_reset) begin
         rstn = 1'b0;
         #1;
         check("rst mid outs", {busy, done, in_ready, out_valid, sr_en, sr_ld}, 32'd0);
         check("rst mid chain", 32'(chain), 32'd0);
         @(negedge clk);
         rstn = 1'b1;
         check("rst shifts", 32'(en_cnt - en_s), 32'd5);
      end else begin
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         check("abort outs", {busy, done, in_ready, out_valid, sr_en, sr_ld}, 32'd0);
         check("abort out_data", 32'(out_data), 32'd0);
         check("abort shifts", 32'(en_cnt - en_s), 32'd5);
      end
      repeat (3) @(negedge clk);
      check("interrupt no done", 32'(done_cnt - dn_s), 32'd0);
      check("interrupt idle", 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic cap; logic [15:0] pd; logic [7:0] w0, w1;
      int in_st, out_st; logic mid;
      logic [7:0] r0, r1; logic [15:0] chain; int ld;
   } vec_t;
   vec_t v[8];

   initial begin
      logic [WORD_W-1:0] r0, r1;
      int en_s, ld_s, dn_s;
      v[0] = '{1'b0, 16'h0000, 8'hA5, 8'h3C, 0, 0, 1'b0, 8'h00, 8'h00, 16'h3CA5, 0};
      v[1] = '{1'b0, 16'h0000, 8'h00, 8'h00, 0, 0, 1'b0, 8'hA5, 8'h3C, 16'h0000, 0};
      v[2] = '{1'b1, 16'h1234, 8'h55, 8'hAA, 0, 0, 1'b0, 8'h34, 8'h12, 16'hAA55, 1};
      v[3] = '{1'b0, 16'h0000, 8'h0F, 8'hF0, 5, 3, 1'b0, 8'h55, 8'hAA, 16'hF00F, 0};
      v[4] = '{1'b1, 16'hBEEF, 8'h11, 8'h22, 5, 3, 1'b0, 8'hEF, 8'hBE, 16'h2211, 1};
      v[5] = '{1'b0, 16'h0000, 8'h12, 8'h34, 0, 0, 1'b0, 8'h10, 8'hF9, 16'h3412, 0};
      v[6] = '{1'b0, 16'h0000, 8'h56, 8'h78, 0, 0, 1'b0, 8'h00, 8'h00, 16'h7856, 0};
      v[7] = '{1'b0, 16'h0000, 8'h9A, 8'hBC, 0, 0, 1'b1, 8'h56, 8'h78, 16'hBC9A, 0};

      rstn = 1'b0; start = 1'b0; capture = 1'b0; abort = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset outs", {busy, done, in_ready, out_valid, sr_d, sr_en, sr_ld}, 32'd0);
      check("reset out_data", 32'(out_data), 32'd0);
      rstn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         if (i == 5) interrupt(1'b0, 4);
         if (i == 6) interrupt(1'b1, 5);
         en_s = en_cnt; ld_s = ld_cnt; dn_s = done_cnt;
         pd = v[i].pd;
         do_start(v[i].cap);
         feed(v[i].w0, v[i].in_st);
         if (v[i].mid) begin
            start = 1'b1; capture = 1'b1;
            @(negedge clk);
            start = 1'b0; capture = 1'b0;
         end
         drain(v[i].out_st, r0);
         feed(v[i].w1, v[i].in_st);
         drain(v[i].out_st, r1);
         repeat (3) @(negedge clk);
         check($sformatf("v%0d readback0", i), 32'(r0), 32'(v[i].r0));
         check($sformatf("v%0d readback1", i), 32'(r1), 32'(v[i].r1));
         check($sformatf("v%0d chain", i), 32'(chain), 32'(v[i].chain));
         check($sformatf("v%0d sr_en cycles", i), 32'(en_cnt - en_s), 32'(CHAIN_LEN));
         check($sformatf("v%0d sr_ld cycles", i), 32'(ld_cnt - ld_s), 32'(v[i].ld));
         check($sformatf("v%0d done pulses", i), 32'(done_cnt - dn_s), 32'd1);
         check($sformatf("v%0d busy after", i), 32'(busy), 32'd0);
         if (v[i].ld != 0)
            check($sformatf("v%0d ld before shift", i), 32'(ld_en_snap), 32'(en_s));
      end
      check("ld/en overlap", 32'(overlap), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
